// File: rtl/gcd_app.sv
// Binary (Stein) GCD application behind a RAH-style queue pair: pulls one operand
// packet, iterates to the GCD, then pushes one result packet with its iteration count.
module gcd_app #(
  parameter int DATA_WIDTH = 48,
  parameter int OPW        = 24
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  empty,
  output logic                  rden,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  wren
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    CALC,
    OUT
  } state_e;

  state_e                state_q, state_d;
  logic [OPW-1:0]        a_q, a_d;
  logic [OPW-1:0]        b_q, b_d;
  logic [OPW-1:0]        a0_q, a0_d;
  logic [OPW-1:0]        b0_q, b0_d;
  logic [4:0]            k_q, k_d;
  logic [15:0]           count_q, count_d;
  logic                  rden_q, rden_d;
  logic                  wren_q, wren_d;
  logic [DATA_WIDTH-1:0] dataout_q, dataout_d;

  logic [OPW-1:0] a_in;
  logic [OPW-1:0] b_in;
  logic [OPW-1:0] a_minus_b;
  logic [OPW-1:0] b_minus_a;
  logic [OPW-1:0] gcd_shift;
  logic [15:0]    count_inc;

  assign a_in      = datain[DATA_WIDTH-1:OPW];
  assign b_in      = datain[OPW-1:0];
  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;
  assign gcd_shift = a_q << k_q;
  // The count field saturates rather than wrapping.
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    a0_d      = a0_q;
    b0_d      = b0_q;
    k_d       = k_q;
    count_d   = count_q;
    rden_d    = 1'b0;
    wren_d    = 1'b0;
    dataout_d = dataout_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
          rden_d  = 1'b1;
        end
      end

      REQ: begin
        state_d = LOAD;
      end

      LOAD: begin
        a_d     = a_in;
        b_d     = b_in;
        a0_d    = a_in;
        b0_d    = b_in;
        k_d     = 5'd0;
        count_d = 16'd0;
        if ((a_in == '0) || (b_in == '0)) begin
          state_d   = OUT;
          wren_d    = 1'b1;
          dataout_d = {a_in | b_in, 16'd0, 7'd0, 1'b1};
        end else begin
          state_d = CALC;
        end
      end

      CALC: begin
        count_d = count_inc;
        if (a_q == b_q) begin
          state_d   = OUT;
          wren_d    = 1'b1;
          dataout_d = {gcd_shift, count_inc, 7'd0, 1'b0};
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 5'd1;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          // Both odd: the difference is even, so halving it keeps the step exact.
          a_d = a_minus_b >> 1;
        end else begin
          b_d = b_minus_a >> 1;
        end
      end

      OUT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      a0_q      <= '0;
      b0_q      <= '0;
      k_q       <= 5'd0;
      count_q   <= 16'd0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a0_q      <= a0_d;
      b0_q      <= b0_d;
      k_q       <= k_d;
      count_q   <= count_d;
      rden_q    <= rden_d;
      wren_q    <= wren_d;
      dataout_q <= dataout_d;
    end
  end

  assign rden    = rden_q;
  assign wren    = wren_q;
  assign dataout = dataout_q;

endmodule

// File: tb/tb_gcd_app.sv
// Self-checking bench for gcd_app: queue model on the input side, Euclid-based
// reference for the GCD, and a scoreboard of expected result packets and latencies.
module tb_gcd_app;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [47:0] datain = 48'd0;
  logic        empty = 1'b1;
  logic        rden;
  logic        wren;
  logic [47:0] dataout;

  gcd_app #(
    .DATA_WIDTH(48),
    .OPW(24)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .datain(datain),
    .empty(empty),
    .rden(rden),
    .dataout(dataout),
    .wren(wren)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] pkt;
    logic [47:0] expv;
    int          lat;
  } item_t;

  logic [47:0] fifo_q[$];
  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rden_cyc = 0;
  int          rden_cnt = 0;
  int          wren_cnt = 0;
  bit          inflight = 1'b0;

  // Reference: GCD by Euclid's remainder method; iteration count by walking the
  // binary-GCD rules on plain integers.
  function automatic logic [47:0] model(input logic [23:0] a0, input logic [23:0] b0,
                                        output int n);
    int unsigned x, y, t, g;
    n = 0;
    if (a0 == 24'd0 || b0 == 24'd0) return {a0 | b0, 16'd0, 8'h01};
    x = a0;
    y = b0;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    x = a0;
    y = b0;
    while (n < 10000) begin
      n++;
      if (x == y) break;
      if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
      else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return {g[23:0], (n > 65535) ? 16'hFFFF : n[15:0], 8'h00};
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [23:0] a, input logic [23:0] b,
                      input logic [47:0] spec_exp, input bit use_spec);
    item_t       it;
    int          n;
    logic [47:0] m;
    m       = model(a, b, n);
    it.pkt  = {a, b};
    it.expv = use_spec ? spec_exp : m;
    it.lat  = 2 + ((n > 65535) ? 65535 : n);
    fifo_q.push_back({a, b});
    exp_q.push_back(it);
    empty = 1'b0;
  endtask

  // One clock: sample outputs on the falling edge, serve the queue, score results.
  task automatic step();
    item_t it;
    @(negedge clk);
    cyc++;
    check("rden_wren_exclusive", {47'd0, rden & wren}, 48'd0);
    if (rden === 1'b1) begin
      check("rden_single_in_flight", {47'd0, inflight}, 48'd0);
      check("rden_queue_nonempty", {47'd0, fifo_q.size() > 0}, 48'd1);
      inflight = 1'b1;
      rden_cyc = cyc;
      rden_cnt++;
      if (fifo_q.size() > 0) datain = fifo_q.pop_front();
    end
    if (wren === 1'b1) begin
      wren_cnt++;
      check("wren_expected", {47'd0, exp_q.size() > 0}, 48'd1);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        $display("pkt A=%h B=%h dataout=%h expected=%h latency=%0d", it.pkt[47:24],
                 it.pkt[23:0], dataout, it.expv, cyc - rden_cyc);
        check("dataout", dataout, it.expv);
        check("rden_to_wren_latency", 48'(cyc - rden_cyc), 48'(it.lat));
      end
      inflight = 1'b0;
    end
    empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    repeat (2) step();
  endtask

  initial begin
    int          r0;
    int          w0;
    int          n;
    int          mode;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] f;

    // Reset held with a packet already queued: nothing may be requested.
    push(24'd12, 24'd18, {24'h000006, 16'd4, 7'd0, 1'b0}, 1'b1);
    repeat (3) step();
    check("reset_rden", {47'd0, rden}, 48'd0);
    check("reset_wren", {47'd0, wren}, 48'd0);
    check("reset_dataout", dataout, 48'd0);
    rstn = 1'b1;
    drain(100);

    push(24'd0, 24'd7, {24'h000007, 16'd0, 8'h01}, 1'b1);
    drain(100);
    push(24'd0, 24'd0, 48'h000000_000001, 1'b1);
    drain(100);
    push(24'hFFFFFF, 24'hFFFFFF, {24'hFFFFFF, 16'd1, 8'h00}, 1'b1);
    drain(100);
    push(24'h800000, 24'h000001, 48'd0, 1'b0);
    drain(200);
    push(24'h800000, 24'h400000, 48'd0, 1'b0);
    drain(200);
    check("dataout_holds_after_out", dataout[47:24], 24'h400000);

    // Three back-to-back packets with the queue never empty in between.
    r0 = rden_cnt;
    w0 = wren_cnt;
    push(24'd48, 24'd180, 48'd0, 1'b0);
    push(24'd7, 24'd0, 48'd0, 1'b0);
    push(24'd1001, 24'd143, 48'd0, 1'b0);
    drain(400);
    check("burst_rden_count", 48'(rden_cnt - r0), 48'd3);
    check("burst_wren_count", 48'(wren_cnt - w0), 48'd3);
    r0 = rden_cnt;
    repeat (10) step();
    check("no_rden_when_empty", 48'(rden_cnt), 48'(r0));

    // Reset mid-calculation abandons the packet; the next one still completes.
    r0 = rden_cnt;
    push(24'h800000, 24'h000001, 48'd0, 1'b0);
    push(24'd84, 24'd36, 48'd0, 1'b0);
    n = 0;
    while (rden_cnt == r0 && n < 50) begin
      step();
      n++;
    end
    check("rden_before_abort", 48'(rden_cnt - r0), 48'd1);
    repeat (5) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("abort_rden", {47'd0, rden}, 48'd0);
    check("abort_wren", {47'd0, wren}, 48'd0);
    check("abort_dataout", dataout, 48'd0);
    inflight = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    w0 = wren_cnt;
    drain(200);
    check("abort_then_one_wren", 48'(wren_cnt - w0), 48'd1);

    // Randomized operands with a mix of shapes.
    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          a = 24'($urandom);
          b = 24'($urandom);
        end
        1: begin
          f = 24'($urandom_range(1, 4095));
          a = 24'(f * 24'($urandom_range(1, 4095)));
          b = 24'(f * 24'($urandom_range(1, 4095)));
        end
        2: begin
          a = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom);
          b = (a == 24'd0) ? 24'($urandom) : 24'd0;
        end
        default: begin
          a = 24'($urandom_range(1, 255)) << $urandom_range(0, 15);
          b = 24'($urandom_range(1, 255)) << $urandom_range(0, 15);
        end
      endcase
      push(a, b, 48'd0, 1'b0);
      if ($urandom_range(0, 2) == 0) push(b, a, 48'd0, 1'b0);
      drain(600);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_app.md
GCD_APP -- requirements
Module: gcd_app

Interface
REQ-001 Parameter DATA_WIDTH, default 48, RAH packet width; the block SHALL support only 48.
REQ-002 Parameter OPW, default 24, operand width; the block SHALL support only DATA_WIDTH/2.
REQ-003 Port clk, input, 1: single clock, shared as the app's RAH rd_clk and wr_clk.
REQ-004 Port rstn, input, 1: reset, synchronous and active-low.
REQ-005 Port datain, input, 48: packet from the decoder queue; valid in the cycle after rden is high.
REQ-006 Port empty, input, 1: decoder queue empty.
REQ-007 Port rden, output, 1: registered one-cycle read request to the decoder queue.
REQ-008 Port dataout, output, 48: result packet to the encoder.
REQ-009 Port wren, output, 1: registered one-cycle write strobe to the encoder.

Function
REQ-010 Input packet layout SHALL be: A = datain[47:24], B = datain[23:0], both unsigned.
REQ-011 Output packet layout SHALL be:
- dataout[47:24] = gcd(A,B)
- dataout[23:8] = CALC cycle count, saturating at 0xFFFF
- dataout[7:1] = 0
- dataout[0] = zero_flag, set when A==0 or B==0
REQ-012 FSM states SHALL be IDLE, REQ, LOAD, CALC and OUT.
REQ-013 IDLE SHALL go to REQ on the next edge when empty==0; otherwise it SHALL stay in IDLE.
REQ-014 rden SHALL be 1 exactly during the REQ cycle; REQ SHALL always go to LOAD.
REQ-015 LOAD SHALL capture datain into a, b, A0 and B0, and SHALL clear k and count.
REQ-016 From LOAD, if A==0 or B==0 the FSM SHALL go to OUT; otherwise it SHALL go to CALC.
REQ-017 Each CALC cycle SHALL increment count and evaluate in priority order:
- a==b: result = a<<k, go to OUT
- both a and b even: a>>=1, b>>=1, k++
- a even: a>>=1
- b even: b>>=1
- a>b: a = (a-b)>>1
- otherwise: b = (b-a)>>1
REQ-018 k SHALL be 5 bits wide; result = a<<k SHALL be truncated to 24 bits, which cannot overflow for valid inputs.
REQ-019 Zero operands SHALL produce gcd = A0|B0 (0 for 0,0), count = 0 and zero_flag = 1.
REQ-020 In OUT, wren SHALL be 1 for exactly one cycle with dataout valid in that same cycle, and the FSM SHALL return to IDLE.
REQ-021 dataout SHALL hold its last value until the next OUT.
REQ-022 The block SHALL have no backpressure input; the encoder FIFO is sized by the system so writes are never dropped.
REQ-023 At most one packet SHALL be in flight; a new rden SHALL NOT be issued before wren of the previous packet.
REQ-024 Latency SHALL be: rden to wren = 2 + count cycles (2 for zero operands), and wren to next rden ≥ 2 cycles.
REQ-025 empty changing while in REQ, LOAD, CALC or OUT SHALL have no effect on the current packet.
REQ-026 rden and wren SHALL never both be 1 in the same cycle.

Reset
REQ-027 When rstn==0 at a clk edge: the FSM SHALL go to IDLE, rden, wren and dataout SHALL be 0, and a, b, k and count SHALL be 0.
REQ-028 Reset asserted mid-CALC SHALL abandon the packet with no wren; that packet is lost.
REQ-029 The first rden after rstn rises SHALL occur no earlier than the second edge with empty==0.

Verification
REQ-030 A=12, B=18 -> one wren; dataout = {24'h000006, 16'd4, 7'd0, 1'b0}; rden-to-wren = 6 cycles.
REQ-031 A=0, B=7 -> dataout = {24'h000007, 16'd0, 8'h01}; A=0, B=0 -> dataout = 48'h000000_000001; rden-to-wren = 2 cycles each.
REQ-032 A=B=0xFFFFFF -> gcd 0xFFFFFF, count 1. A=0x800000, B=0x000001 -> gcd 1, no hang. A=0x800000, B=0x400000 -> gcd 0x400000.
REQ-033 Queue holding 3 packets with empty held low -> 3 rden pulses, 3 wren pulses in order, never overlapping; after the queue drains, empty=1 -> no further rden.
REQ-034 rstn pulled low for 1 cycle during CALC -> no wren for that packet; outputs 0; the next queued packet is processed correctly.
